// File: rtl/fifo_read_stream.sv
// Drains a first-word-fall-through-less async FIFO read port into a valid/ready
// stream through a 3-entry skid buffer sized to cover the 1-cycle read latency.
module fifo_read_stream #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 32
) (
  input  logic                read_clk,
  input  logic                read_rst_n,
  input  logic                enable,
  output logic                p_read_en,
  input  logic [BITS-1:0]     p_read_data,
  input  logic                p_read_empty,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BITS-1:0]     m_data,
  output logic [CNT_BITS-1:0] xfer_count,
  output logic                overflow_err
);

  localparam logic [1:0] LAST_SLOT = 2'd2;
  localparam logic [1:0] FULL_OCC  = 2'd3;

  logic [1:0]      occ;
  logic [1:0]      head;
  logic [1:0]      tail;
  logic            infl;
  logic            armed;
  logic [BITS-1:0] skid [3];

  logic            push;
  logic            pop;
  logic            store;
  logic [2:0]      committed;

  function automatic logic [1:0] wrap_inc(input logic [1:0] ptr);
    return (ptr == LAST_SLOT) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Slots already spoken for: buffered words plus the word still on its way
  // from the FIFO. A new read is only safe if it still fits after both land.
  assign committed = {1'b0, occ} + {2'b00, infl};

  // armed holds off reads until one full cycle after reset release; the
  // request never looks at m_ready, so there is no comb path from the sink.
  assign p_read_en = armed & enable & ~p_read_empty & (committed <= 3'd2);

  assign push    = infl;
  assign pop     = m_valid & m_ready;
  assign store   = push & ((occ != FULL_OCC) | pop);
  assign m_valid = (occ != 2'd0);
  assign m_data  = skid[head];

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      occ          <= 2'd0;
      head         <= 2'd0;
      tail         <= 2'd0;
      infl         <= 1'b0;
      armed        <= 1'b0;
      xfer_count   <= '0;
      overflow_err <= 1'b0;
      // NOTE: the storage is reset too, so m_data reads 0 while in reset
      // instead of exposing whatever the last stream left behind.
      for (int i = 0; i < 3; i++) begin
        skid[i] <= '0;
      end
    end else begin
      // NOTE: every register here uses <= so all of them see the pre-edge
      // occ/head/tail; blocking writes would make the update order matter.
      armed <= 1'b1;
      infl  <= p_read_en;

      if (store) begin
        skid[tail] <= p_read_data;
        tail       <= wrap_inc(tail);
      end

      if (pop) begin
        head       <= wrap_inc(head);
        xfer_count <= xfer_count + CNT_BITS'(1);
      end

      if (push && (occ == FULL_OCC) && !pop) begin
        overflow_err <= 1'b1;
      end

      // Push-with-pop leaves occ alone; at occ=1 the new word becomes head.
      unique case ({store, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: a queue-based FIFO model feeds the read port and
// a scoreboard checks the stream against the order of accepted reads.
module tb_fifo_read_stream;

  localparam int BITS     = 32;
  localparam int CNT_BITS = 10;
  localparam int DEPTH    = 4096;

  logic                read_clk = 1'b0;
  logic                read_rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                p_read_en;
  logic [BITS-1:0]     p_read_data;
  logic                p_read_empty;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [BITS-1:0]     m_data;
  logic [CNT_BITS-1:0] xfer_count;
  logic                overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 read_clk = ~read_clk;

  fifo_read_stream #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .read_clk     (read_clk),
    .read_rst_n   (read_rst_n),
    .enable       (enable),
    .p_read_en    (p_read_en),
    .p_read_data  (p_read_data),
    .p_read_empty (p_read_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .xfer_count   (xfer_count),
    .overflow_err (overflow_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- async FIFO read-side model ----------------
  logic [BITS-1:0] fifo_mem [DEPTH];
  int              wr_cnt = 0;
  int              rd_cnt = 0;
  logic            force_empty = 1'b0;
  logic [BITS-1:0] exp_q [$];

  assign p_read_empty = force_empty || (wr_cnt == rd_cnt);

  // Read data and the read pointer move in the NBA region so the DUT samples
  // a stable empty flag and last cycle's data at the same edge.
  always @(posedge read_clk) begin
    if (read_rst_n && p_read_en && !p_read_empty) begin
      p_read_data <= fifo_mem[rd_cnt % DEPTH];
      exp_q.push_back(fifo_mem[rd_cnt % DEPTH]);
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Anything accepted but not yet delivered is lost on reset.
  always @(negedge read_rst_n) exp_q.delete();

  // ---------------- stream monitor / scoreboard ----------------
  int              model_xfers = 0;
  int              run_len = 0;
  int              max_run = 0;
  logic            prev_stall = 1'b0;
  logic [BITS-1:0] prev_data = '0;

  always @(negedge read_clk) begin
    if (!read_rst_n) begin
      model_xfers = 0;
      run_len     = 0;
      max_run     = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall && m_valid) check("hold_stable", 64'(m_data), 64'(prev_data));
      if (m_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (m_valid && m_ready) begin
        check("xfer_has_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("xfer_order", 64'(m_data), 64'(exp_q.pop_front()));
        model_xfers++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic push_word(input logic [BITS-1:0] w);
    fifo_mem[wr_cnt % DEPTH] = w;
    wr_cnt++;
  endtask

  task automatic apply_reset();
    read_rst_n  = 1'b0;
    enable      = 1'b0;
    m_ready     = 1'b0;
    force_empty = 1'b0;
    tick();
    tick();
    wr_cnt     = rd_cnt;
    read_rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_xfers(input int target, input int budget, input bit rand_ready);
    int n = 0;
    while (model_xfers < target && n < budget) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("xfer_budget", 64'(model_xfers), 64'(target));
  endtask

  typedef struct {
    logic en;
    logic fe;
    logic rdy;
    logic exp_rd;
    logic exp_vld;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    int   base;

    // Occupancy walk with the FIFO well stocked: fill to 3, stall, drain.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset with a non-empty FIFO and enable high.
    read_rst_n = 1'b0;
    enable     = 1'b1;
    for (int i = 0; i < 4; i++) push_word(BITS'(32'h55 + i));
    tick();
    tick();
    check("rst_read_en", 64'(p_read_en), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_count", 64'(xfer_count), 64'd0);
    check("rst_overflow", 64'(overflow_err), 64'd0);
    read_rst_n = 1'b1;
    #1;
    check("first_cycle_no_read", 64'(p_read_en), 64'd0);
    tick();
    check("read_after_arm", 64'(p_read_en), 64'd1);

    // Table-driven occupancy walk.
    apply_reset();
    base = rd_cnt;
    for (int i = 0; i < 8; i++) push_word(BITS'(32'hA0 + i));
    for (int i = 0; i < 13; i++) begin
      enable      = vecs[i].en;
      force_empty = vecs[i].fe;
      m_ready     = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_read_en", i), 64'(p_read_en), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vecs[i].exp_vld));
      tick();
    end
    check("vec_reads", 64'(rd_cnt - base), 64'd4);
    check("vec_count", 64'(xfer_count), 64'd4);

    // Full-rate streaming of 1..16.
    apply_reset();
    for (int i = 1; i <= 16; i++) push_word(BITS'(i));
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_xfers(16, 100, 1'b0);
    repeat (3) tick();
    check("stream_count", 64'(xfer_count), 64'd16);
    check("stream_run", 64'(max_run), 64'd16);
    check("stream_idle", 64'(m_valid), 64'd0);

    // Backpressure: sink stalled for 20 cycles with 8 words waiting.
    apply_reset();
    base = rd_cnt;
    for (int i = 0; i < 8; i++) push_word(BITS'(32'h100 + i));
    enable = 1'b1;
    repeat (20) tick();
    check("bp_reads", 64'(rd_cnt - base), 64'd3);
    check("bp_valid", 64'(m_valid), 64'd1);
    check("bp_head", 64'(m_data), 64'h100);
    check("bp_read_en", 64'(p_read_en), 64'd0);
    m_ready = 1'b1;
    wait_xfers(8, 100, 1'b0);
    tick();
    check("bp_count", 64'(xfer_count), 64'd8);
    check("bp_overflow", 64'(overflow_err), 64'd0);

    // Empty gating, then enable drop with two words buffered.
    apply_reset();
    base   = rd_cnt;
    enable = 1'b1;
    repeat (3) begin
      tick();
      check("empty_read_en", 64'(p_read_en), 64'd0);
    end
    push_word(BITS'(32'hBEEF0001));
    push_word(BITS'(32'hBEEF0002));
    repeat (4) tick();
    check("gate_reads", 64'(rd_cnt - base), 64'd2);
    check("gate_valid", 64'(m_valid), 64'd1);
    enable  = 1'b0;
    m_ready = 1'b1;
    wait_xfers(2, 20, 1'b0);
    tick();
    check("gate_drained", 64'(m_valid), 64'd0);
    push_word(BITS'(32'hBEEF0003));
    tick();
    check("gate_read_en", 64'(p_read_en), 64'd0);
    repeat (3) tick();
    check("gate_no_reads", 64'(rd_cnt - base), 64'd2);
    check("gate_count", 64'(xfer_count), 64'd2);

    // Reset mid-stream after 5 of 10 transfers.
    apply_reset();
    for (int i = 0; i < 10; i++) push_word(BITS'(32'hC00 + i));
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_xfers(5, 50, 1'b0);
    read_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_count", 64'(xfer_count), 64'd0);
    check("mid_rst_overflow", 64'(overflow_err), 64'd0);
    check("mid_rst_read_en", 64'(p_read_en), 64'd0);
    tick();
    read_rst_n = 1'b1;
    #1;
    check("mid_release_no_read", 64'(p_read_en), 64'd0);
    repeat (20) tick();
    check("mid_drained", 64'(exp_q.size()), 64'd0);

    // Random 50% backpressure over 1000 words, then run past the counter wrap.
    apply_reset();
    void'($urandom(32'd20240611));
    for (int i = 0; i < 1000; i++) push_word(BITS'($urandom));
    enable = 1'b1;
    wait_xfers(1000, 20000, 1'b1);
    m_ready = 1'b1;
    repeat (5) tick();
    check("rand_count", 64'(xfer_count), 64'(1000 % (1 << CNT_BITS)));
    check("rand_overflow", 64'(overflow_err), 64'd0);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 30; i++) push_word(BITS'($urandom));
    wait_xfers(1030, 200, 1'b0);
    tick();
    check("wrap_count", 64'(xfer_count), 64'(1030 % (1 << CNT_BITS)));

    enable = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_stream.md
FIFO_READ_STREAM -- requirements
Module: fifo_read_stream

Interface
REQ-001 SHALL have parameter BITS, default 32: data width; equals the BITS of the async FIFO it drains.
REQ-002 SHALL have parameter CNT_BITS, default 32: width of the transfer counter.
REQ-003 SHALL have port read_clk, input, 1 bit: the single clock, shared with the FIFO read domain; one clock domain only.
REQ-004 SHALL have port read_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: permits issuing new FIFO reads.
REQ-006 SHALL have port p_read_en, output, 1 bit: FIFO read request.
REQ-007 SHALL have port p_read_data, input, BITS bits: FIFO read data.
REQ-008 SHALL have port p_read_empty, input, 1 bit: FIFO empty flag.
REQ-009 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-010 SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-011 SHALL have port m_data, output, BITS bits: stream data.
REQ-012 SHALL have port xfer_count, output, CNT_BITS bits: count of completed stream transfers.
REQ-013 SHALL have port overflow_err, output, 1 bit: sticky internal-overflow flag.

Function
REQ-014 SHALL model FIFO read timing as follows: a read is accepted at rising edge E when p_read_en=1 and p_read_empty=0, and p_read_data is valid between E and E+1.
REQ-015 SHALL contain a 3-entry in-order skid buffer with occupancy occ in 0..3 and a 1-bit in-flight flag infl; infl is set at edge E and cleared at E+1.
REQ-016 SHALL drive p_read_en = enable & ~p_read_empty & (occ + infl <= 2), using no combinational path from m_ready.
REQ-017 SHALL push p_read_data into the buffer tail at edge E+1 whenever infl=1.
REQ-018 SHALL drive m_valid = (occ != 0) and m_data = the buffer head entry; read-accept to m_valid latency is 2 edges.
REQ-019 SHALL pop the head on every edge where m_valid & m_ready.
REQ-020 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-021 SHALL, on a push and a pop in the same edge, keep occ unchanged and preserve order, including the occ=1 case where the pushed word becomes the head.
REQ-022 SHALL sustain one transfer per cycle in steady state (occ=1, infl=1) with m_ready=1 and the FIFO non-empty.
REQ-023 SHALL, on deassertion of enable, issue no new reads and still deliver all in-flight and buffered words.
REQ-024 SHALL keep p_read_en at 0 when p_read_empty=1, even if enable=1.
REQ-025 SHALL increment xfer_count by 1 per transfer, wrapping from 2^CNT_BITS-1 to 0.
REQ-026 SHALL set overflow_err when a push occurs with occ=3 and no pop; the flag is sticky until reset and the word is dropped.
REQ-027 SHALL index the buffer with wrapping head/tail pointers modulo 3, so any push/pop sequence yields the FIFO order of the accepted reads.

Reset
REQ-028 SHALL, on read_rst_n=0, asynchronously clear occ, infl, pointers, buffer entries, xfer_count and overflow_err.
REQ-029 SHALL drive p_read_en=0, m_valid=0, m_data=0, xfer_count=0 and overflow_err=0 while read_rst_n=0.
REQ-030 SHALL discard buffered and in-flight data on reset mid-operation, and SHALL not issue a read in the first cycle after release.

Verification
REQ-031 SHALL verify reset: read_rst_n=0 with FIFO non-empty and enable=1 -> p_read_en=0, m_valid=0, m_data=0, xfer_count=0.
REQ-032 SHALL verify streaming: write 0x00000001..0x00000010 into the FIFO, enable=1, m_ready=1 -> 16 transfers in order, xfer_count=16, and 16 consecutive m_valid cycles once the buffer is primed.
REQ-033 SHALL verify backpressure: m_ready=0 for 20 cycles with FIFO holding 8 words -> exactly 3 reads issued, occ=3, m_data=first word stable; on m_ready=1 all 8 words are delivered in order.
REQ-034 SHALL verify empty and enable gating: FIFO empty -> p_read_en=0; enable=0 with 2 words buffered -> both delivered, then m_valid=0, p_read_en=0.
REQ-035 SHALL verify reset mid-stream: after 5 of 10 words are transferred, pulse read_rst_n low -> m_valid=0 immediately, xfer_count=0, overflow_err=0.
REQ-036 SHALL verify random m_ready at 50% with seeded stimulus over 1000 words -> scoreboard order match, xfer_count=1000, overflow_err=0.
